// File: rtl/heap_sort_stream.sv
// rtl/heap_sort_stream.sv - streaming binary-heap sorter (load burst, emit sorted)
//
// Purpose:
//   Accepts a burst of up to ARRAY_SIZE keys on the input stream, keeps them in
//   an internal binary heap, and then emits them in sorted order on the output
//   stream. The heap does one compare/swap per cycle.
//
// Parameters:
//   ELEMENT_SIZE  key width in bits
//   ARRAY_SIZE    heap capacity (>= 2)
//   MIN_MAX       1 = ascending output (min-heap), 0 = descending (max-heap)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   abort      synchronous clear back to IDLE, heap emptied
//   in_valid   input key valid
//   in_ready   sorter can accept a key
//   in_data    input key
//   in_last    final key of the burst
//   out_valid  out_data holds the current extremum
//   out_ready  downstream accepts
//   out_data   sorted key (zero while out_valid is low)
//   out_last   out_data is the final key of the burst
//   count      keys currently held
//   busy       state is not IDLE
//   full_stop  one-cycle pulse: load ended by capacity rather than in_last
//   order_err  sticky output-order violation flag
//
// Build option:
//   HEAP_SORT_STREAM_ORDER_CHECK_EN  enables the output-order checker driving
//                                    order_err; when undefined order_err is 0.

module heap_sort_stream #(
    parameter int ELEMENT_SIZE = 9,
    parameter int ARRAY_SIZE   = 256,
    parameter int MIN_MAX      = 1,
    localparam int CW          = $clog2(ARRAY_SIZE + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    abort,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ELEMENT_SIZE-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ELEMENT_SIZE-1:0] out_data,
    output logic                    out_last,
    output logic [CW-1:0]           count,
    output logic                    busy,
    output logic                    full_stop,
    output logic                    order_err
);

    localparam int IW = $clog2(ARRAY_SIZE);
    localparam logic [CW-1:0] CAP = CW'(ARRAY_SIZE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SIFT_UP = 3'd2,
        S_EXTRACT = 3'd3,
        S_SIFT_DN = 3'd4
    } state_t;

    // True when key a must sit above key b in the heap (strict: ties never swap).
    function automatic logic beats(input logic [ELEMENT_SIZE-1:0] a,
                                   input logic [ELEMENT_SIZE-1:0] b);
        return (MIN_MAX != 0) ? (a < b) : (a > b);
    endfunction

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [IW-1:0]           cur_q, cur_d;
    logic                    done_q, done_d;      // burst terminated, drain after sift
    logic                    in_ready_q, in_ready_d;
    logic                    full_stop_q, full_stop_d;

    logic [ELEMENT_SIZE-1:0] heap_q [ARRAY_SIZE];

    // Two write ports: one for loads/replacements, both for swaps.
    logic                    we_a, we_b;
    logic [IW-1:0]           wa_idx, wb_idx;
    logic [ELEMENT_SIZE-1:0] wa_data, wb_data;

    logic                    accept;
    logic                    out_fire;
    logic                    cap_hit;

    logic [IW-1:0]           parent;
    logic [CW-1:0]           cnt_m1;
    logic [IW+1:0]           lch, rch, cnt_x;
    logic                    l_ok, r_ok;
    logic [ELEMENT_SIZE-1:0] key_cur, key_par, key_l, key_r, key_tail;
    logic [IW-1:0]           best_idx;
    logic [ELEMENT_SIZE-1:0] best_key;
    logic                    best_leaf;

    assign accept   = in_valid & in_ready_q;
    assign out_fire = (state_q == S_EXTRACT) & out_ready;
    assign cap_hit  = (count_q + CW'(1)) == CAP;

    // Heap navigation. Children are computed two bits wider than an index so
    // 2*cur+2 never wraps back into range.
    assign parent   = (cur_q - IW'(1)) >> 1;
    assign cnt_m1   = count_q - CW'(1);
    assign lch      = {1'b0, cur_q, 1'b1};
    assign rch      = lch + (IW + 2)'(1);
    assign cnt_x    = (IW + 2)'(count_q);
    assign l_ok     = lch < cnt_x;
    assign r_ok     = rch < cnt_x;

    assign key_cur  = heap_q[cur_q];
    assign key_par  = heap_q[parent];
    assign key_l    = heap_q[lch[IW-1:0]];
    assign key_r    = heap_q[rch[IW-1:0]];
    assign key_tail = heap_q[cnt_m1[IW-1:0]];

    // Sift-down winner among the cursor and whichever children exist.
    always_comb begin
        best_idx = cur_q;
        best_key = key_cur;
        if (l_ok && beats(key_l, best_key)) begin
            best_idx = lch[IW-1:0];
            best_key = key_l;
        end
        if (r_ok && beats(key_r, best_key)) begin
            best_idx = rch[IW-1:0];
            best_key = key_r;
        end
        best_leaf = {1'b0, best_idx, 1'b1} >= cnt_x;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cur_d       = cur_q;
        done_d      = done_q;
        full_stop_d = 1'b0;
        we_a        = 1'b0;
        wa_idx      = '0;
        wa_data     = '0;
        we_b        = 1'b0;
        wb_idx      = '0;
        wb_data     = '0;

        if (abort) begin
            state_d = S_IDLE;
            count_d = '0;
            cur_d   = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        we_a        = 1'b1;
                        wa_idx      = count_q[IW-1:0];
                        wa_data     = in_data;
                        count_d     = count_q + CW'(1);
                        cur_d       = count_q[IW-1:0];
                        done_d      = in_last | cap_hit;
                        full_stop_d = cap_hit & ~in_last;
                        if (count_q != '0) begin
                            state_d = S_SIFT_UP;
                        end else if (in_last | cap_hit) begin
                            state_d = S_EXTRACT;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_SIFT_UP: begin
                    if (beats(key_cur, key_par)) begin
                        we_a    = 1'b1;
                        wa_idx  = cur_q;
                        wa_data = key_par;
                        we_b    = 1'b1;
                        wb_idx  = parent;
                        wb_data = key_cur;
                        cur_d   = parent;
                        if (parent == '0) begin
                            state_d = done_q ? S_EXTRACT : S_LOAD;
                        end
                    end else begin
                        state_d = done_q ? S_EXTRACT : S_LOAD;
                    end
                end
                S_EXTRACT: begin
                    if (out_ready) begin
                        // Move the tail to the root; a 1-key heap just empties.
                        we_a    = 1'b1;
                        wa_idx  = '0;
                        wa_data = key_tail;
                        count_d = cnt_m1;
                        cur_d   = '0;
                        if (cnt_m1 == '0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b0;
                        end else begin
                            state_d = S_SIFT_DN;
                        end
                    end
                end
                S_SIFT_DN: begin
                    if (best_idx != cur_q) begin
                        we_a    = 1'b1;
                        wa_idx  = cur_q;
                        wa_data = best_key;
                        we_b    = 1'b1;
                        wb_idx  = best_idx;
                        wb_data = key_cur;
                        cur_d   = best_idx;
                        // Landing on a leaf ends the sift without an extra check cycle.
                        if (best_leaf) begin
                            state_d = S_EXTRACT;
                        end
                    end else begin
                        state_d = S_EXTRACT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                    done_d  = 1'b0;
                end
            endcase
        end

        in_ready_d = ((state_d == S_IDLE) || (state_d == S_LOAD)) && (count_d != CAP);
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            cur_q       <= '0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            full_stop_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            cur_q       <= cur_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            full_stop_q <= full_stop_d;
        end
    end

    // Heap storage: contents are don't-care whenever count says so, so no reset.
    always_ff @(posedge clk) begin
        if (we_a) begin
            heap_q[wa_idx] <= wa_data;
        end
        if (we_b) begin
            heap_q[wb_idx] <= wb_data;
        end
    end

    // Outputs
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q == S_EXTRACT);
        out_data  = out_valid ? heap_q[0] : '0;
        out_last  = out_valid && (count_q == CW'(1));
        count     = count_q;
        busy      = (state_q != S_IDLE);
        full_stop = full_stop_q;
    end

`ifdef HEAP_SORT_STREAM_ORDER_CHECK_EN
    logic [ELEMENT_SIZE-1:0] last_key_q;
    logic                    seen_q;       // a key of this burst was already emitted
    logic                    order_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key_q  <= '0;
            seen_q      <= 1'b0;
            order_err_q <= 1'b0;
        end else if (abort) begin
            seen_q      <= 1'b0;
            order_err_q <= 1'b0;
        end else if (out_fire) begin
            last_key_q <= heap_q[0];
            seen_q     <= (count_q != CW'(1));
            if (seen_q && beats(heap_q[0], last_key_q)) begin
                order_err_q <= 1'b1;
            end
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_heap_sort_stream.sv
// tb/tb_heap_sort_stream.sv - directed self-checking bench for heap_sort_stream

module tb_heap_sort_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            abort;
    logic            out_ready;
    logic            in_last;
    logic [8:0]      in_data;
    logic [2:0]      in_valid;
    logic [2:0]      in_ready, out_valid, out_last, busy, full_stop, order_err;
    logic [2:0][8:0] out_data;
    logic [3:0]      cnt_a, cnt_b;
    logic [8:0]      cnt_c;

    int checks = 0;
    int errors = 0;

    heap_sort_stream #(.ELEMENT_SIZE(9), .ARRAY_SIZE(8), .MIN_MAX(1)) dut_asc (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .out_last(out_last[0]), .count(cnt_a), .busy(busy[0]),
        .full_stop(full_stop[0]), .order_err(order_err[0])
    );

    heap_sort_stream #(.ELEMENT_SIZE(9), .ARRAY_SIZE(8), .MIN_MAX(0)) dut_desc (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .out_last(out_last[1]), .count(cnt_b), .busy(busy[1]),
        .full_stop(full_stop[1]), .order_err(order_err[1])
    );

    heap_sort_stream #(.ELEMENT_SIZE(9), .ARRAY_SIZE(256), .MIN_MAX(1)) dut_big (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
        .out_last(out_last[2]), .count(cnt_c), .busy(busy[2]),
        .full_stop(full_stop[2]), .order_err(order_err[2])
    );

    function automatic logic [8:0] cnt_of(input int s);
        case (s)
            0:       return {5'd0, cnt_a};
            1:       return {5'd0, cnt_b};
            default: return cnt_c;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int s, input logic [8:0] k, input logic l);
        int n = 0;
        @(negedge clk);
        in_data     = k;
        in_last     = l;
        in_valid[s] = 1'b1;
        while (!in_ready[s] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(in_ready[s]), 32'd1);
        @(posedge clk);
        #1;
        in_valid[s] = 1'b0;
        in_last     = 1'b0;
    endtask

    task automatic pop(input int s, input logic [8:0] ek, input logic el,
                       input string tag, input int ecnt);
        int n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!out_valid[s] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid[s]), 32'd1);
        check({tag, "_data"}, 32'(out_data[s]), 32'(ek));
        check({tag, "_last"}, 32'(out_last[s]), 32'(el));
        check({tag, "_count"}, 32'(cnt_of(s)), 32'(ecnt));
        @(posedge clk);
        #1;
    endtask

    logic [8:0] keys8  [8] = '{9'h005, 9'h003, 9'h1FF, 9'h000, 9'h007, 9'h003, 9'h002, 9'h100};
    logic [8:0] asc8   [8] = '{9'h000, 9'h002, 9'h003, 9'h003, 9'h005, 9'h007, 9'h100, 9'h1FF};
    logic [8:0] desc8  [8] = '{9'h1FF, 9'h100, 9'h007, 9'h005, 9'h003, 9'h003, 9'h002, 9'h000};
    logic [8:0] capk   [8] = '{9'd10, 9'd4, 9'd9, 9'd1, 9'd7, 9'd7, 9'd0, 9'd3};
    logic [8:0] caps   [8] = '{9'd0, 9'd1, 9'd3, 9'd4, 9'd7, 9'd7, 9'd9, 9'd10};
    logic [8:0] bpk    [8] = '{9'h006, 9'h006, 9'h001, 9'h08F, 9'h002, 9'h1FE, 9'h000, 9'h040};
    logic [8:0] bps    [8] = '{9'h000, 9'h001, 9'h002, 9'h006, 9'h006, 9'h040, 9'h08F, 9'h1FE};
    logic [8:0] abk    [6] = '{9'd20, 9'd4, 9'd15, 9'd8, 9'd16, 9'd23};

    logic [8:0] gotq [$];
    logic [8:0] bigq [$];
    int         early;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready[0]), 32'd0);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_out_data", 32'(out_data[0]), 32'd0);
        check("rst_out_last", 32'(out_last[0]), 32'd0);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_full_stop", 32'(full_stop[0]), 32'd0);
        check("rst_order_err", 32'(order_err[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready[0]), 32'd1);

        // Ascending burst of 8, in_last on the 8th
        for (int i = 0; i < 8; i++) send(0, keys8[i], i == 7);
        check("asc_full_stop", 32'(full_stop[0]), 32'd0);
        check("asc_count_full", 32'(cnt_a), 32'd8);
        for (int i = 0; i < 8; i++) pop(0, asc8[i], i == 7, "asc", 8 - i);
        check("asc_idle_busy", 32'(busy[0]), 32'd0);
        check("asc_idle_count", 32'(cnt_a), 32'd0);
        check("asc_order_err", 32'(order_err[0]), 32'd0);

        // Descending burst
        for (int i = 0; i < 8; i++) send(1, keys8[i], i == 7);
        for (int i = 0; i < 8; i++) pop(1, desc8[i], i == 7, "desc", 8 - i);
        check("desc_idle_busy", 32'(busy[1]), 32'd0);

        // Capacity stop, then a 9th key held off until drained; 9th is a single-key burst
        for (int i = 0; i < 8; i++) send(0, capk[i], 1'b0);
        check("cap_full_stop_pulse", 32'(full_stop[0]), 32'd1);
        @(posedge clk);
        #1;
        check("cap_full_stop_clear", 32'(full_stop[0]), 32'd0);
        gotq.delete();
        early = 0;
        fork
            send(0, 9'h0AB, 1'b1);
            begin
                int n = 0;
                out_ready = 1'b1;
                while (gotq.size() < 8 && n < 1000) begin
                    @(negedge clk);
                    n++;
                    if (busy[0] && in_ready[0]) early++;
                    if (out_valid[0]) gotq.push_back(out_data[0]);
                end
            end
        join
        check("cap_drain_size", 32'(gotq.size()), 32'd8);
        for (int i = 0; i < 8 && i < gotq.size(); i++) check("cap_drain_data", 32'(gotq[i]), 32'(caps[i]));
        check("cap_ready_while_busy", 32'(early), 32'd0);
        check("single_valid_next", 32'(out_valid[0]), 32'd1);
        check("single_data", 32'(out_data[0]), 32'h0AB);
        check("single_last", 32'(out_last[0]), 32'd1);
        pop(0, 9'h0AB, 1'b1, "single", 1);
        check("single_idle", 32'(busy[0]), 32'd0);

        // Backpressure with random out_ready
        for (int i = 0; i < 8; i++) send(0, bpk[i], i == 7);
        gotq.delete();
        begin
            int         n = 0;
            logic       stalled = 1'b0;
            logic [8:0] held = '0;
            while (gotq.size() < 8 && n < 2000) begin
                @(negedge clk);
                n++;
                if (stalled) begin
                    check("bp_hold_valid", 32'(out_valid[0]), 32'd1);
                    check("bp_hold_data", 32'(out_data[0]), 32'(held));
                end
                out_ready = 1'($urandom_range(0, 1));
                stalled = 1'b0;
                if (out_valid[0]) begin
                    if (out_ready) begin
                        gotq.push_back(out_data[0]);
                    end else begin
                        stalled = 1'b1;
                        held    = out_data[0];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check("bp_size", 32'(gotq.size()), 32'd8);
        for (int i = 0; i < 8 && i < gotq.size(); i++) check("bp_data", 32'(gotq[i]), 32'(bps[i]));

        // Abort during SIFT_DN with count 5
        for (int i = 0; i < 6; i++) send(0, abk[i], i == 5);
        pop(0, 9'd4, 1'b0, "abort_pop", 6);
        check("abort_pre_count", 32'(cnt_a), 32'd5);
        check("abort_pre_valid", 32'(out_valid[0]), 32'd0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_count", 32'(cnt_a), 32'd0);
        check("abort_valid", 32'(out_valid[0]), 32'd0);
        check("abort_in_ready", 32'(in_ready[0]), 32'd1);

        // Reset mid-LOAD on the 256-entry sorter
        for (int i = 0; i < 3; i++) send(2, 9'(i + 40), 1'b0);
        check("midload_count", 32'(cnt_c), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_count", 32'(cnt_c), 32'd0);
        check("midrst_busy", 32'(busy[2]), 32'd0);
        check("midrst_valid", 32'(out_valid[2]), 32'd0);
        check("midrst_in_ready", 32'(in_ready[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 256-key random burst
        bigq.delete();
        for (int i = 0; i < 256; i++) begin
            logic [8:0] k;
            k = 9'($urandom_range(0, 511));
            bigq.push_back(k);
            send(2, k, i == 255);
        end
        check("big_count", 32'(cnt_c), 32'd256);
        check("big_full_stop", 32'(full_stop[2]), 32'd0);
        bigq.sort();
        for (int i = 0; i < 256; i++) pop(2, bigq[i], i == 255, "big", 256 - i);
        check("big_idle", 32'(busy[2]), 32'd0);
        check("big_order_err", 32'(order_err[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
